seven_seg_scan_ctrl: RTL and testbench

Parametrised N-digit multiplexed seven-segment scan controller, the successor to the fixed 4-digit decimal driver. It scans NUM_DIGITS common-anode digits with hex decode, decimal points and optional leading-zero blanking. PWM brightness control is included. A valid/ready update port latches new display data only at frame boundaries, so the display never tears. It sits between the vote-count/BCD logic and the board's segment/anode pins.

---
 rtl/seven_seg_pkg.sv | 51 +++++
 rtl/seven_seg_scan_ctrl_if.sv | 28 ++
 rtl/seven_seg_decode.sv | 13 +
 rtl/seven_seg_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: active-low segment codes (index 0 = segment a),
// hex decode helper and default sizing for the scan controller.
package seven_seg_pkg;

    localparam int NUM_DIGITS_DEFAULT     = 4;
    localparam int REFRESH_CYCLES_DEFAULT = 100000;
    localparam int BRIGHT_W_DEFAULT       = 4;

    localparam logic [0:6] SEG_0 = 7'b000_0001;
    localparam logic [0:6] SEG_1 = 7'b100_1111;
    localparam logic [0:6] SEG_2 = 7'b001_0010;
    localparam logic [0:6] SEG_3 = 7'b000_0110;
    localparam logic [0:6] SEG_4 = 7'b100_1100;
    localparam logic [0:6] SEG_5 = 7'b010_0100;
    localparam logic [0:6] SEG_6 = 7'b010_0000;
    localparam logic [0:6] SEG_7 = 7'b000_1111;
    localparam logic [0:6] SEG_8 = 7'b000_0000;
    localparam logic [0:6] SEG_9 = 7'b000_0100;
    localparam logic [0:6] SEG_A = 7'b000_1000;
    localparam logic [0:6] SEG_B = 7'b110_0000;
    localparam logic [0:6] SEG_C = 7'b011_0001;
    localparam logic [0:6] SEG_D = 7'b100_0010;
    localparam logic [0:6] SEG_E = 7'b011_0000;
    localparam logic [0:6] SEG_F = 7'b011_1000;

    localparam logic [0:6] SEG_BLANK = 7'b111_1111;

    function automatic logic [0:6] hex_to_seg(input logic [3:0] nibble);
        hex_to_seg = SEG_BLANK;
        case (nibble)
            4'h0: hex_to_seg = SEG_0;
            4'h1: hex_to_seg = SEG_1;
            4'h2: hex_to_seg = SEG_2;
            4'h3: hex_to_seg = SEG_3;
            4'h4: hex_to_seg = SEG_4;
            4'h5: hex_to_seg = SEG_5;
            4'h6: hex_to_seg = SEG_6;
            4'h7: hex_to_seg = SEG_7;
            4'h8: hex_to_seg = SEG_8;
            4'h9: hex_to_seg = SEG_9;
            4'hA: hex_to_seg = SEG_A;
            4'hB: hex_to_seg = SEG_B;
            4'hC: hex_to_seg = SEG_C;
            4'hD: hex_to_seg = SEG_D;
            4'hE: hex_to_seg = SEG_E;
            4'hF: hex_to_seg = SEG_F;
            default: hex_to_seg = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-data update port: the source offers nibbles/dp with valid, the
// scan controller raises ready only on the frame-boundary cycle.
interface seven_seg_scan_ctrl_if
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
);

    logic                    upd_valid;
    logic                    upd_ready;
    logic [4*NUM_DIGITS-1:0] upd_nibbles;
    logic [NUM_DIGITS-1:0]   upd_dp;

    modport master (
        output upd_valid,
        output upd_nibbles,
        output upd_dp,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_nibbles,
        input  upd_dp,
        output upd_ready
    );

endinterface

// File: rtl/seven_seg_decode.sv
// Combinational hex nibble to active-low segment decode with a blank override,
// shared by the display blocks.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [0:6] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : hex_to_seg(nibble_i);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// N-digit multiplexed common-anode seven-segment scanner with hex decode, leading-zero
// blanking, PWM brightness and frame-synchronised updates. Optional blink: SEVEN_SEG_BLINK_EN.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = NUM_DIGITS_DEFAULT,
    parameter int REFRESH_CYCLES = REFRESH_CYCLES_DEFAULT,
    parameter int BRIGHT_W       = BRIGHT_W_DEFAULT
`ifdef SEVEN_SEG_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 125
`endif
) (
    input  logic                  clk_100MHz,
    input  logic                  reset,
    seven_seg_scan_ctrl_if.slave  upd,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
    output logic [0:6]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] digit,
    output logic                  frame_tick
);

    localparam int TIMER_W = $clog2(REFRESH_CYCLES);
    localparam int SEL_W   = $clog2(NUM_DIGITS);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_CYCLES - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST   = SEL_W'(NUM_DIGITS - 1);

    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [BRIGHT_W-1:0]     pwm_q;
    logic [4*NUM_DIGITS-1:0] nib_q;
    logic [NUM_DIGITS-1:0]   dp_shadow_q;
    logic                    tick_q;
    logic [0:6]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   digit_q, digit_d;

    logic                    timer_last;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic                    hide;

    always_comb begin
        timer_last = (timer_q == TIMER_LAST);
        frame_end  = timer_last && (sel_q == SEL_LAST);
        timer_d    = timer_last ? '0 : timer_q + 1'b1;
        sel_d      = sel_q;
        if (timer_last) begin
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
        end
    end

    assign upd.upd_ready = frame_end;

    // Walk down from the most significant digit; a non-zero nibble or a lit dp ends the zero run.
    always_comb begin
        logic leading;
        leading  = blank_lz;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (leading && (nib_q[4*i +: 4] == 4'h0) && !dp_shadow_q[i]) begin
                lz_blank[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic               blink_off_q;

    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_q <= '0;
                blink_off_q <= ~blink_off_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign hide = blink_off_q && blink_mask[sel_q];
`else
    assign hide = 1'b0;
`endif

    assign cur_nib   = nib_q[4*sel_q +: 4];
    assign cur_blank = lz_blank[sel_q] | hide;

    seven_seg_decode u_decode (
        .nibble_i (cur_nib),
        .blank_i  (cur_blank),
        .seg_o    (seg_d)
    );

    always_comb begin
        dp_d    = ~(dp_shadow_q[sel_q] & ~cur_blank);
        digit_d = '1;
        if ((pwm_q <= brightness) && !hide) begin
            digit_d[sel_q] = 1'b0;
        end
    end

    // Segments and anodes share one register stage so they always switch together.
    always_ff @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            timer_q     <= '0;
            sel_q       <= '0;
            pwm_q       <= '0;
            nib_q       <= '0;
            dp_shadow_q <= '0;
            tick_q      <= 1'b0;
            seg_q       <= SEG_BLANK;
            dp_q        <= 1'b1;
            digit_q     <= '1;
        end else begin
            timer_q <= timer_d;
            sel_q   <= sel_d;
            pwm_q   <= pwm_q + 1'b1;
            tick_q  <= frame_end;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            digit_q <= digit_d;
            if (upd.upd_valid && frame_end) begin
                nib_q       <= upd.upd_nibbles;
                dp_shadow_q <= upd.upd_dp;
            end
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign digit      = digit_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl (3 digits, 16-cycle slots) against a
// cycle-index reference model; inputs change on the falling edge, outputs checked there too.
module tb_seven_seg_scan_ctrl;

    localparam int ND    = 3;
    localparam int RC    = 16;
    localparam int BW    = 4;
    localparam int FRAME = RC * ND;

    localparam logic [6:0] SEG_REF [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic          clk_100MHz = 1'b0;
    logic          reset      = 1'b0;
    logic          blank_lz   = 1'b0;
    logic [BW-1:0] brightness = '1;
    logic [0:6]    seg;
    logic          dp;
    logic [ND-1:0] digit;
    logic          frame_tick;

    seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) upd ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS     (ND),
        .REFRESH_CYCLES (RC),
        .BRIGHT_W       (BW)
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .upd        (upd.slave),
        .blank_lz   (blank_lz),
        .brightness (brightness),
`ifdef SEVEN_SEG_BLINK_EN
        .blink_mask ('0),
`endif
        .seg        (seg),
        .dp         (dp),
        .digit      (digit),
        .frame_tick (frame_tick)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: everything follows from the number of cycles since reset release.
    int unsigned   cyc      = 0;
    logic [4*ND-1:0] modelNib = '0;
    logic [ND-1:0] modelDp  = '0;
    logic [6:0]    expSeg   = 7'h7F;
    logic          expDp    = 1'b1;
    logic [ND-1:0] expDigit = '1;
    logic          expTick  = 1'b0;
    int            slot;
    int            lead;
    logic          blanked;

    always @(posedge clk_100MHz or negedge reset) begin
        if (!reset) begin
            cyc      = 0;
            modelNib = '0;
            modelDp  = '0;
            expSeg   = 7'h7F;
            expDp    = 1'b1;
            expDigit = '1;
            expTick  = 1'b0;
        end else begin
            slot = int'((cyc / RC) % ND);
            lead = 0;
            for (int i = 0; i < ND; i++) begin
                if (modelNib[4*i +: 4] != 4'h0 || modelDp[i]) lead = i;
            end
            blanked  = blank_lz && (slot > lead);
            expSeg   = blanked ? 7'h7F : SEG_REF[modelNib[4*slot +: 4]];
            expDp    = blanked ? 1'b1 : ~modelDp[slot];
            expDigit = '1;
            if ((cyc % (1 << BW)) <= brightness) expDigit[slot] = 1'b0;
            expTick  = (cyc % FRAME) == FRAME - 1;
            if (upd.upd_valid && expTick) begin
                modelNib = upd.upd_nibbles;
                modelDp  = upd.upd_dp;
            end
            cyc++;
        end
    end

    always @(negedge clk_100MHz) begin
        checkOutput("seg", 32'(seg), 32'(expSeg));
        checkOutput("dp", 32'(dp), 32'(expDp));
        checkOutput("digit", 32'(digit), 32'(expDigit));
        checkOutput("frame_tick", 32'(frame_tick), 32'(expTick));
        checkOutput("upd_ready", 32'(upd.upd_ready), 32'(reset && ((cyc % FRAME) == FRAME - 1)));
    end

    task automatic applyStimulus(input logic [4*ND-1:0] nib, input logic [ND-1:0] dpv,
                                 input logic blank, input logic [BW-1:0] bright);
        int waited;
        @(negedge clk_100MHz);
        blank_lz   = blank;
        brightness = bright;
        repeat ($urandom_range(0, 20)) @(negedge clk_100MHz);
        upd.upd_valid   = 1'b1;
        upd.upd_nibbles = nib;
        upd.upd_dp      = dpv;
        waited = 0;
        @(negedge clk_100MHz);
        while (!upd.upd_ready && waited < 2 * FRAME) begin
            @(negedge clk_100MHz);
            waited++;
        end
        if (!upd.upd_ready) checkOutput("ready_timeout", 32'(upd.upd_ready), 32'd1);
        @(negedge clk_100MHz);
        upd.upd_valid = 1'b0;
        repeat (FRAME + 2) @(negedge clk_100MHz);
    endtask

    initial begin
        int waited;
        logic [4*ND-1:0] rnib;
        upd.upd_valid   = 1'b0;
        upd.upd_nibbles = '0;
        upd.upd_dp      = '0;
        repeat (3) @(negedge clk_100MHz);
        #2 reset = 1'b1;
        repeat (2 * FRAME + 3) @(negedge clk_100MHz);

        applyStimulus(12'hA50, 3'b000, 1'b0, 4'hF);

        applyStimulus(12'h210, 3'b000, 1'b0, 4'hF);
        applyStimulus(12'h543, 3'b010, 1'b0, 4'hF);
        applyStimulus(12'h876, 3'b000, 1'b0, 4'hF);
        applyStimulus(12'hBA9, 3'b010, 1'b0, 4'hF);
        applyStimulus(12'hEDC, 3'b000, 1'b0, 4'hF);
        applyStimulus(12'h10F, 3'b111, 1'b0, 4'hF);

        applyStimulus(12'h070, 3'b000, 1'b1, 4'hF);
        applyStimulus(12'h000, 3'b000, 1'b1, 4'hF);
        applyStimulus(12'h000, 3'b100, 1'b1, 4'hF);
        applyStimulus(12'h005, 3'b001, 1'b1, 4'hF);

        applyStimulus(12'h321, 3'b000, 1'b0, 4'h3);
        applyStimulus(12'h321, 3'b000, 1'b0, 4'h0);
        applyStimulus(12'h321, 3'b000, 1'b0, 4'hF);

        for (int k = 0; k < 15; k++) begin
            rnib = 12'($urandom);
            if ($urandom_range(0, 1) == 1) rnib[11:8] = 4'h0;
            if ($urandom_range(0, 2) == 0) rnib[7:4]  = 4'h0;
            applyStimulus(rnib, 3'($urandom_range(0, 7) & $urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 4'($urandom));
        end

        brightness = 4'hF;
        waited = 0;
        while (((cyc / RC) % ND) != 2 && waited < 2 * FRAME) begin
            @(negedge clk_100MHz);
            waited++;
        end
        checkOutput("reach_digit2", 32'((cyc / RC) % ND), 32'd2);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_seg", 32'(seg), 32'h7F);
        checkOutput("rst_dp", 32'(dp), 32'd1);
        checkOutput("rst_digit", 32'(digit), 32'((1 << ND) - 1));
        checkOutput("rst_tick", 32'(frame_tick), 32'd0);
        repeat (4) @(negedge clk_100MHz);
        #2 reset = 1'b1;
        repeat (2 * FRAME + 5) @(negedge clk_100MHz);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
